fetch_queue: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-entry fetch/stall path of the 5-stage core. It generates fetch PCs and issues pipelined icache requests with up to MAX_OUTSTANDING in flight. In-order responses are buffered with their PCs in a DEPTH-entry queue and handed to decode over a valid/ready handshake. A redirect (taken jump/branch from execute) flushes the queue and discards in-flight stale responses without stalling the memory interface.

---
 rtl/fetch_queue_pkg.sv | 12 +
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/fetch_queue.sv | 147 ++++++++++++++
 tb/tb_fetch_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and helpers for the fetch front end.
// Holds the reset PC, the NOP encoding and a pointer-width helper.
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET  = 32'h0000_2000;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and full/empty flags.
// Ports: clk, i_rst_n, i_flush, i_push/i_wdata, i_pop/o_rdata,
//        o_count, o_full, o_empty.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop)  r_rptr <= nxt(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Pipelined instruction fetch front end with a decoupling buffer.
// Ports: clk/reset, icache request+response, redirect, out_* to decode, busy.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                DEPTH           = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter int                ADDR_W          = 32,
  parameter int                INSTR_W         = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(PC_RESET)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  icache_addr,
  output logic               icache_re,
  input  logic               icache_req_ready,
  input  logic               icache_resp_valid,
  input  logic [INSTR_W-1:0] icache_dout,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic               busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [OW-1:0]     r_outstanding;
  logic [OW-1:0]     r_drop_cnt;

  logic [OW-1:0]     w_live;
  logic [CW-1:0]     w_count;
  logic [OW-1:0]     w_tag_count;
  logic [ADDR_W-1:0] w_tag_pc;
  logic [BW-1:0]     w_head;
  logic              w_re;
  logic              w_accept;
  logic              w_resp;
  logic              w_drop;
  logic              w_push;
  logic              w_pop;
  logic              w_buf_full;
  logic              w_buf_empty;
  logic              w_tag_full;
  logic              w_tag_empty;

  assign w_live = r_outstanding - r_drop_cnt;

  // Issue only with a buffer slot reserved for every live response.
  assign w_re = reset && !redirect_valid
             && (32'(r_outstanding) < MAX_OUTSTANDING)
             && ((32'(w_count) + 32'(w_live)) < DEPTH);

  assign w_accept = w_re && icache_req_ready;
  assign w_resp   = icache_resp_valid;
  assign w_drop   = redirect_valid || (r_drop_cnt != '0);
  assign w_push   = w_resp && !w_drop;
  assign w_pop    = out_valid && out_ready && !redirect_valid;

  fetch_fifo #(
    .WIDTH (ADDR_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_q (
    .clk     (clk),
    .i_rst_n (reset),
    .i_flush (1'b0),
    .i_push  (w_accept),
    .i_wdata (r_fetch_pc),
    .i_pop   (w_resp),
    .o_rdata (w_tag_pc),
    .o_count (w_tag_count),
    .o_full  (w_tag_full),
    .o_empty (w_tag_empty)
  );

  fetch_fifo #(
    .WIDTH (BW),
    .DEPTH (DEPTH)
  ) u_buf_q (
    .clk     (clk),
    .i_rst_n (reset),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_wdata ({w_tag_pc, icache_dout}),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_buf_full),
    .o_empty (w_buf_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
    end else if (w_accept) begin
      r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_outstanding <= '0;
    end else begin
      unique case ({w_accept, w_resp})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // A response landing in the redirect cycle is itself stale,
  // so only the remainder still in flight is left to drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_drop_cnt <= '0;
    end else if (redirect_valid) begin
      r_drop_cnt <= r_outstanding - OW'(w_resp);
    end else if (w_resp && (r_drop_cnt != '0)) begin
      r_drop_cnt <= r_drop_cnt - OW'(1);
    end
  end

  assign icache_addr = r_fetch_pc;
  assign icache_re   = w_re;
  assign out_valid   = !w_buf_empty;
  assign out_pc      = out_valid ? w_head[BW-1 -: ADDR_W] : '0;
  assign out_instr   = out_valid ? w_head[INSTR_W-1:0] : '0;
  assign busy        = (r_outstanding != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(w_resp && w_tag_empty));
      assert (!(w_push && w_buf_full && !w_pop));
      assert (!(w_accept && w_tag_full && !w_resp));
      assert (32'(w_tag_count) == 32'(r_outstanding));
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised bench for fetch_queue against a transaction-level model.
// Model tracks requests by epoch and the decode stream as restart+4k.
module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam int          MAXO   = 2;
  localparam logic [31:0] RST_PC = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic        icache_req_ready;
  logic        icache_resp_valid;
  logic [31:0] icache_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        busy;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .ADDR_W          (32),
    .INSTR_W         (32),
    .RESET_PC        (RST_PC)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .icache_addr       (icache_addr),
    .icache_re         (icache_re),
    .icache_req_ready  (icache_req_ready),
    .icache_resp_valid (icache_resp_valid),
    .icache_dout       (icache_dout),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_instr         (out_instr),
    .busy              (busy)
  );

  typedef struct {
    logic [31:0] pc;
    int          ep;
    int          due;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t        pend[$];
  ent_t        mq[$];
  logic [31:0] acc_addr[$];
  logic [31:0] m_fetch;
  logic [31:0] m_stream;
  int          epoch;
  int          cyc;
  int          lat;
  int          n_chk;
  int          n_bad;
  int          n_acc;
  int          t_acc;
  int          t_val;
  bit          armed;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst_n, input logic redir,
                      input logic [31:0] rpc, input logic rrdy,
                      input logic ordy);
    int   live;
    int   due;
    logic exp_re;
    logic rv;
    req_t r;
    @(negedge clk);
    live = 0;
    foreach (pend[i]) if (pend[i].ep == epoch) live++;
    rv = (pend.size() != 0) && (pend[0].due <= cyc);
    reset             = rst_n;
    redirect_valid    = redir;
    redirect_pc       = rpc;
    icache_req_ready  = rrdy;
    out_ready         = ordy;
    icache_resp_valid = rv;
    icache_dout       = rv ? mem_word(pend[0].pc) : $urandom;
    exp_re = rst_n && !redir && (pend.size() < MAXO)
          && ((mq.size() + live) < DEPTH);
    #1;
    if (armed) begin
      chk("re", icache_re, exp_re);
      chk("addr", icache_addr, m_fetch);
      chk("valid", out_valid, mq.size() != 0);
      chk("busy", busy, pend.size() != 0);
      if (mq.size() != 0) begin
        chk("pc", out_pc, mq[0].pc);
        chk("instr", out_instr, mq[0].ins);
      end else begin
        chk("pc_idle", out_pc, 0);
        chk("instr_idle", out_instr, 0);
      end
      if (out_valid && ordy && !redir && rst_n) begin
        chk("seq", out_pc, m_stream);
        m_stream = m_stream + 32'd4;
      end
      if (t_val < 0 && out_valid) t_val = cyc;
      if (icache_re && rrdy) begin
        n_acc++;
        acc_addr.push_back(icache_addr);
        if (t_acc < 0) t_acc = cyc;
      end
    end
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      pend.delete();
      mq.delete();
      m_fetch  = RST_PC;
      m_stream = RST_PC;
      epoch++;
    end else begin
      if (redir) mq.delete();
      else if (ordy && mq.size() != 0) void'(mq.pop_front());
      if (rv) begin
        r = pend.pop_front();
        if (r.ep == epoch && !redir)
          mq.push_back('{pc: r.pc, ins: mem_word(r.pc)});
      end
      if (redir) begin
        epoch++;
        m_fetch  = rpc;
        m_stream = rpc;
      end else if (exp_re && rrdy) begin
        due = cyc - 1 + lat;
        if (pend.size() != 0 && due < pend[$].due) due = pend[$].due;
        pend.push_back('{pc: m_fetch, ep: epoch, due: due});
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  initial begin
    logic [31:0] rpc;
    reset = 1'b0;
    icache_req_ready = 1'b0;
    icache_resp_valid = 1'b0;
    icache_dout = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    m_fetch = RST_PC;
    m_stream = RST_PC;
    epoch = 0; cyc = 0; lat = 1;
    n_chk = 0; n_bad = 0; n_acc = 0;
    t_acc = -1; t_val = -1;
    armed = 1'b0;

    repeat (2) step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    armed = 1'b1;

    repeat (40) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("first_latency", 64'(t_val - t_acc), 2);

    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    n_acc = 0;
    repeat (10) step(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_accepts", 64'(n_acc), 4);
    chk("stall_head", out_pc, RST_PC);
    repeat (12) step(1'b1, 1'b0, '0, 1'b1, 1'b1);

    lat = 3;
    repeat (7) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h0000_3000, 1'b1, 1'b1);
    repeat (20) step(1'b1, 1'b0, '0, 1'b1, 1'b1);

    for (int k = 0; k < 800; k++) begin
      lat = $urandom_range(1, 3);
      rpc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0
                                        : ($urandom & 32'hFFFF_FFFC);
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 19) == 0), rpc,
           (k < 300) ? k[0] : ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 3) != 0));
    end

    lat = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1);
    acc_addr.delete();
    repeat (8) step(1'b1, 1'b0, '0, 1'b1, 1'b1);
    chk("wrap_n", 64'(acc_addr.size() >= 3), 1);
    if (acc_addr.size() >= 3) begin
      chk("wrap0", acc_addr[0], 32'hFFFF_FFF8);
      chk("wrap1", acc_addr[1], 32'hFFFF_FFFC);
      chk("wrap2", acc_addr[2], 32'h0000_0000);
    end

    step(1'b0, 1'b0, '0, 1'b1, 1'b1);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_addr", icache_addr, RST_PC);
    chk("rst_busy", busy, 0);
    repeat (10) step(1'b1, 1'b0, '0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
